// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display path.
// Segment patterns are active-high gfedcba; pins carry their inverse.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [7:0] seg_word_t;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

endpackage

// File: rtl/seven_seg_pat_dec.sv
// Combinational inverse of the hex segment table: 7-bit active-high pattern to nibble.
// Patterns outside the table yield nibble 0 with err_o set.
module seven_seg_pat_dec
  import seven_seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b0;
    case (pat_i)
      SEG_HEX_0: nibble_o = 4'h0;
      SEG_HEX_1: nibble_o = 4'h1;
      SEG_HEX_2: nibble_o = 4'h2;
      SEG_HEX_3: nibble_o = 4'h3;
      SEG_HEX_4: nibble_o = 4'h4;
      SEG_HEX_5: nibble_o = 4'h5;
      SEG_HEX_6: nibble_o = 4'h6;
      SEG_HEX_7: nibble_o = 4'h7;
      SEG_HEX_8: nibble_o = 4'h8;
      SEG_HEX_9: nibble_o = 4'h9;
      SEG_HEX_A: nibble_o = 4'hA;
      SEG_HEX_B: nibble_o = 4'hB;
      SEG_HEX_C: nibble_o = 4'hC;
      SEG_HEX_D: nibble_o = 4'hD;
      SEG_HEX_E: nibble_o = 4'hE;
      SEG_HEX_F: nibble_o = 4'hF;
      default:   err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side capture of a 4-digit multiplexed 7-seg display: synchronise, settle,
// decode each digit into shadow registers, publish the 16-bit value once all four are seen.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dig,
  input  logic [7:0]  seg,
  output logic [15:0] num,
  output logic [3:0]  dp,
  output logic        num_valid,
  output logic        frame_err,
  output logic        active
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0][3:0] dig_sync_q;
  logic [SYNC_STAGES-1:0][7:0] seg_sync_q;
  logic [3:0]                  ds;
  seg_word_t                   ss;
  logic [11:0]                 prev_q;
  logic [SW-1:0]               settle_q, settle_d;
  logic [WW-1:0]               wd_q, wd_d;
  logic                        active_q, active_d;
  logic                        strobe_ok, stable, capture, timeout, complete;
  logic [1:0]                  dig_idx;
  logic [3:0]                  dec_nib;
  logic                        dec_err;

  logic [NUM_DIGITS-1:0][3:0]  nib_q, nib_d;
  logic [NUM_DIGITS-1:0]       sdp_q, sdp_d;
  logic [NUM_DIGITS-1:0]       serr_q, serr_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic [15:0]                 num_q;
  logic [3:0]                  dp_q;
  logic                        num_valid_q, frame_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sync_q <= '0;
      seg_sync_q <= '0;
    end else begin
      dig_sync_q <= {dig_sync_q[SYNC_STAGES-2:0], dig};
      seg_sync_q <= {seg_sync_q[SYNC_STAGES-2:0], seg};
    end
  end

  assign ds = dig_sync_q[SYNC_STAGES-1];
  assign ss = seg_sync_q[SYNC_STAGES-1];

  always_comb begin
    strobe_ok = 1'b1;
    dig_idx   = 2'd0;
    case (ds)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: strobe_ok = 1'b0;
    endcase
  end

  seven_seg_pat_dec u_dec (
    .pat_i    (~ss[6:0]),
    .nibble_o (dec_nib),
    .err_o    (dec_err)
  );

  // The counter saturates at SETTLE_CYCLES, so the SETTLE_CYCLES-1 match fires once per stable period.
  assign stable  = ({ds, ss} == prev_q);
  assign capture = stable && strobe_ok && (settle_q == SW'(SETTLE_CYCLES - 1));
  assign timeout = !capture && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign complete = (mask_q == 4'hF);

  always_comb begin
    settle_d = settle_q;
    if (!stable || !strobe_ok) begin
      settle_d = '0;
    end else if (settle_q != SW'(SETTLE_CYCLES)) begin
      settle_d = settle_q + 1'b1;
    end
  end

  always_comb begin
    wd_d     = wd_q;
    active_d = active_q;
    if (capture) begin
      wd_d     = '0;
      active_d = 1'b1;
    end else if (wd_q != WW'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout) begin
      active_d = 1'b0;
    end
  end

  // Completion clears the mask before a same-cycle capture starts the next frame.
  always_comb begin
    mask_d = mask_q;
    nib_d  = nib_q;
    sdp_d  = sdp_q;
    serr_d = serr_q;
    if (complete) begin
      mask_d = '0;
    end
    if (timeout) begin
      mask_d = '0;
      serr_d = '0;
    end
    if (capture) begin
      mask_d[dig_idx] = 1'b1;
      nib_d[dig_idx]  = dec_nib;
      sdp_d[dig_idx]  = ~ss[7];
      serr_d[dig_idx] = dec_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      settle_q    <= '0;
      wd_q        <= '0;
      active_q    <= 1'b0;
      mask_q      <= '0;
      nib_q       <= '0;
      sdp_q       <= '0;
      serr_q      <= '0;
      num_q       <= '0;
      dp_q        <= '0;
      num_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      prev_q      <= {ds, ss};
      settle_q    <= settle_d;
      wd_q        <= wd_d;
      active_q    <= active_d;
      mask_q      <= mask_d;
      nib_q       <= nib_d;
      sdp_q       <= sdp_d;
      serr_q      <= serr_d;
      num_valid_q <= complete;
      frame_err_q <= complete && (|serr_q);
      if (complete && !(|serr_q)) begin
        num_q <= nib_q;
        dp_q  <= sdp_q;
      end
    end
  end

  assign num       = num_q;
  assign dp        = dp_q;
  assign num_valid = num_valid_q;
  assign frame_err = frame_err_q;
  assign active    = active_q;

endmodule
